// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: default datapath widths and opcode encodings.
// Also used by the ALU and the write-back stage.
package alu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_SLL = 4'b0010;

endpackage

// File: rtl/regfile_2r1w.sv
// Integer register file: two asynchronous read ports, one write port, async reset.
// Entry 0 and any out-of-range address always read zero; there is no bypass here.
module regfile_2r1w #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [XLEN-1:0]   rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [XLEN-1:0]   rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data
);

    logic [XLEN-1:0] regs_q [NREGS];

    function automatic logic live_addr(input logic [ADDR_W-1:0] addr);
        return (addr != '0) && (32'(addr) < NREGS);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && live_addr(wr_addr)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (live_addr(rd_addr_a)) rd_data_a = regs_q[rd_addr_a];
        if (live_addr(rd_addr_b)) rd_data_b = regs_q[rd_addr_b];
    end

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage ahead of the ALU: register read with write-back bypass and a
// one-entry valid/ready output register holding {op, rs1, rs2, rd_addr}.
module alu_operand_fetch
    import alu_pkg::*;
#(
    parameter int unsigned XLEN   = alu_pkg::XLEN,
    parameter int unsigned NREGS  = alu_pkg::NREGS,
    parameter int unsigned ADDR_W = alu_pkg::ADDR_W,
    parameter int unsigned OP_W   = alu_pkg::OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rs1_addr,
    input  logic [ADDR_W-1:0] in_rs2_addr,
    input  logic [ADDR_W-1:0] in_rd_addr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [XLEN-1:0]   out_rs1,
    output logic [XLEN-1:0]   out_rs2,
    output logic [ADDR_W-1:0] out_rd_addr
);

    logic [XLEN-1:0] rf_rs1;
    logic [XLEN-1:0] rf_rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            accept;

    logic              valid_q;
    logic [OP_W-1:0]   op_q;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   rs2_q;
    logic [ADDR_W-1:0] rd_q;

    regfile_2r1w #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (in_rs1_addr),
        .rd_data_a (rf_rs1),
        .rd_addr_b (in_rs2_addr),
        .rd_data_b (rf_rs2),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data)
    );

    // Bypass only addresses the regfile would actually store; r0 and holes stay zero.
    function automatic logic bypass_hit(input logic [ADDR_W-1:0] addr);
        return wb_en && (wb_addr == addr) && (addr != '0) && (32'(addr) < NREGS);
    endfunction

    always_comb begin
        rs1_val = bypass_hit(in_rs1_addr) ? wb_data : rf_rs1;
        rs2_val = bypass_hit(in_rs2_addr) ? wb_data : rf_rs2;
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            op_q    <= in_op;
            rs1_q   <= rs1_val;
            rs2_q   <= rs2_val;
            rd_q    <= in_rd_addr;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid   = valid_q;
    assign out_op      = op_q;
    assign out_rs1     = rs1_q;
    assign out_rs2     = rs2_q;
    assign out_rd_addr = rd_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed bench for alu_operand_fetch: a transaction-level model checked every cycle
// plus literal expectations for each directed scenario.
module tb_alu_operand_fetch;
    import alu_pkg::*;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [ADDR_W-1:0] in_rs1_addr;
    logic [ADDR_W-1:0] in_rs2_addr;
    logic [ADDR_W-1:0] in_rd_addr;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   out_op;
    logic [XLEN-1:0]   out_rs1;
    logic [XLEN-1:0]   out_rs2;
    logic [ADDR_W-1:0] out_rd_addr;

    int n_checks = 0;
    int n_pass   = 0;

    alu_operand_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rs1_addr (in_rs1_addr),
        .in_rs2_addr (in_rs2_addr),
        .in_rd_addr  (in_rd_addr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd_addr (out_rd_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference model: architectural register contents plus the bundle the ALU should see.
    logic [XLEN-1:0]   m_regs [NREGS];
    logic              m_valid;
    logic [OP_W-1:0]   m_op;
    logic [XLEN-1:0]   m_rs1;
    logic [XLEN-1:0]   m_rs2;
    logic [ADDR_W-1:0] m_rd;

    function automatic logic [XLEN-1:0] arch_read(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) m_regs[i] <= '0;
            m_valid <= 1'b0;
            m_op    <= '0;
            m_rs1   <= '0;
            m_rs2   <= '0;
            m_rd    <= '0;
        end else begin
            if (wb_en && wb_addr != 0) m_regs[wb_addr] <= wb_data;
            if (m_valid && !out_ready) begin
                // stalled: bundle frozen, new op refused
            end else if (in_valid) begin
                m_valid <= 1'b1;
                m_op    <= in_op;
                m_rs1   <= arch_read(in_rs1_addr);
                m_rs2   <= arch_read(in_rs2_addr);
                m_rd    <= in_rd_addr;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("reset_out_valid", 32'(out_valid), 32'd0);
        end else begin
            check("model_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            check("model_out_valid", 32'(out_valid), 32'(m_valid));
            check("model_out_op", 32'(out_op), 32'(m_op));
            check("model_out_rs1", out_rs1, m_rs1);
            check("model_out_rs2", out_rs2, m_rs2);
            check("model_out_rd", 32'(out_rd_addr), 32'(m_rd));
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] rs1,
                          input logic [ADDR_W-1:0] rs2, input logic [ADDR_W-1:0] rd);
        in_valid    = 1'b1;
        in_op       = op;
        in_rs1_addr = rs1;
        in_rs2_addr = rs2;
        in_rd_addr  = rd;
    endtask

    task automatic set_wb(input logic en, input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_op(OP_ADD, 5'd0, 5'd0, 5'd0);
        in_valid = 1'b0;
        set_wb(1'b0, 5'd0, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_rs1", out_rs1, 32'd0);
        sync();

        // 1: fresh registers read zero
        set_op(OP_ADD, 5'd1, 5'd2, 5'd7);
        sync();
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_rs1", out_rs1, 32'd0);
        check("t1_rs2", out_rs2, 32'd0);
        sync();

        // 2: write-back then read
        set_wb(1'b1, 5'd3, 32'h0000fffe);
        sync();
        set_wb(1'b0, 5'd0, '0);
        set_op(OP_ADD, 5'd3, 5'd0, 5'd4);
        sync();
        in_valid = 1'b0;
        @(negedge clk);
        check("t2_rs1", out_rs1, 32'h0000fffe);
        check("t2_rs2", out_rs2, 32'd0);
        check("t2_rd", 32'(out_rd_addr), 32'd4);
        check("t2_op", 32'(out_op), 32'd0);
        sync();

        // 3: same-cycle bypass on both ports
        set_wb(1'b1, 5'd5, 32'd32);
        set_op(OP_SUB, 5'd5, 5'd5, 5'd6);
        sync();
        set_wb(1'b0, 5'd0, '0);
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_rs1", out_rs1, 32'd32);
        check("t3_rs2", out_rs2, 32'd32);
        check("t3_op", 32'(out_op), 32'(OP_SUB));
        sync();

        // 4: r0 stays zero, both via regfile and via bypass
        set_wb(1'b1, 5'd0, 32'hdeadbeef);
        sync();
        set_op(OP_SLL, 5'd0, 5'd0, 5'd1);
        sync();
        set_wb(1'b0, 5'd0, '0);
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_rs1", out_rs1, 32'd0);
        check("t4_rs2", out_rs2, 32'd0);
        sync();

        // top register boundary
        set_wb(1'b1, 5'd31, 32'ha5a5_5a5a);
        sync();
        set_wb(1'b0, 5'd0, '0);
        set_op(OP_ADD, 5'd31, 5'd5, 5'd31);
        sync();
        in_valid = 1'b0;
        @(negedge clk);
        check("r31_rs1", out_rs1, 32'ha5a5_5a5a);
        check("r31_rs2", out_rs2, 32'd32);
        sync();

        // 5: stall with a second op waiting; write-back lands during the stall
        out_ready = 1'b0;
        set_op(OP_ADD, 5'd3, 5'd5, 5'd8);
        sync();
        set_op(OP_SUB, 5'd3, 5'd3, 5'd9);
        set_wb(1'b1, 5'd3, 32'd1);
        #1;
        check("t5_in_ready", 32'(in_ready), 32'd0);
        sync();
        set_wb(1'b0, 5'd0, '0);
        for (int i = 0; i < 2; i++) begin
            check("t5_hold_valid", 32'(out_valid), 32'd1);
            check("t5_hold_rs1", out_rs1, 32'h0000fffe);
            check("t5_hold_rd", 32'(out_rd_addr), 32'd8);
            sync();
        end
        check("t5_hold_rs2", out_rs2, 32'd32);
        out_ready = 1'b1;
        sync();
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_second_valid", 32'(out_valid), 32'd1);
        check("t5_second_rd", 32'(out_rd_addr), 32'd9);
        check("t5_second_rs1", out_rs1, 32'd1);
        check("t5_second_rs2", out_rs2, 32'd1);
        sync();
        check("t5_drained", 32'(out_valid), 32'd0);

        // 6: reset during a stall
        out_ready = 1'b0;
        set_op(OP_ADD, 5'd3, 5'd3, 5'd2);
        sync();
        in_valid = 1'b0;
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_clear", 32'(out_valid), 32'd0);
        check("t6_async_rs1", out_rs1, 32'd0);
        sync();
        reset = 1'b0;
        out_ready = 1'b1;
        sync();
        set_op(OP_ADD, 5'd3, 5'd31, 5'd2);
        sync();
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_r3_cleared", out_rs1, 32'd0);
        check("t6_r31_cleared", out_rs2, 32'd0);
        sync();
        sync();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
